// File: rtl/pico_irq_arbiter_if.sv
// Port bundle between pico_irq_arbiter and its requesters / kcpsm6 port bus.
interface pico_irq_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [7:0]                port_id;
  logic                      read_strobe;
  logic                      write_strobe;
  logic [7:0]                out_port;
  logic [7:0]                in_port_data;
  logic                      in_port_hit;
  logic                      interrupt;
  logic                      interrupt_ack;
  logic                      busy;

  modport slave (
    input  req_valid, req_data, port_id, read_strobe, write_strobe, out_port, interrupt_ack,
    output req_ready, in_port_data, in_port_hit, interrupt, busy
  );

  modport master (
    output req_valid, req_data, port_id, read_strobe, write_strobe, out_port, interrupt_ack,
    input  req_ready, in_port_data, in_port_hit, interrupt, busy
  );
endinterface

// File: rtl/pico_irq_arbiter.sv
// Round-robin interrupt-driven input scheduler for the kcpsm6 port bus: captures one
// requester word at a time, interrupts the program, waits for a release write.
module pico_irq_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  BASE_PORT = 8'h10
) (
  input  logic              clk,
  input  logic              reset_n,
  pico_irq_arbiter_if.slave bus
);

  localparam logic [7:0] PortData = BASE_PORT;
  localparam logic [7:0] PortStat = BASE_PORT + 8'd1;
  localparam logic [7:0] PortRel  = BASE_PORT + 8'd2;
  localparam logic [7:0] PortMask = BASE_PORT + 8'd3;

  typedef enum logic [1:0] {StIdle, StIrq, StService} state_e;

  state_e              r_state, w_state_d;
  logic [DATA_W-1:0]   r_hold_data;
  logic [2:0]          r_hold_ch;
  logic [2:0]          r_rr_ptr;
  logic [NUM_REQ-1:0]  r_mask;
  logic [7:0]          r_in_port_data;
  logic                r_in_port_hit;

  logic [NUM_REQ-1:0]   w_eligible, w_rot, w_grant;
  logic [2*NUM_REQ-1:0] w_dbl, w_shift;
  logic                 w_found, w_capture;
  logic [2:0]           w_off, w_sel, w_rr_next;
  logic [3:0]           w_sum;
  logic [DATA_W-1:0]    w_sel_data;
  logic                 w_release, w_mask_wr, w_pending;
  logic [7:0]           w_rd_data;
  logic                 w_rd_hit;
  logic                 w_unused;

  assign w_release = bus.write_strobe && (bus.port_id == PortRel);
  assign w_mask_wr = bus.write_strobe && (bus.port_id == PortMask);
  assign w_pending = (r_state != StIdle);

  // Rotate the eligible vector so that bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    w_eligible = bus.req_valid & ~r_mask;
    w_dbl      = {w_eligible, w_eligible};
    w_shift    = w_dbl >> r_rr_ptr;
    w_rot      = w_shift[NUM_REQ-1:0];
    w_found    = |w_rot;
    w_off      = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
    w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_sel     = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : w_sum[2:0];
    w_rr_next = (32'(w_sel) == NUM_REQ - 32'd1) ? 3'd0 : w_sel + 3'd1;
    // Gated by reset so no handshake can complete while the flops are held in reset.
    w_capture  = (r_state == StIdle) && w_found && reset_n;
    w_grant    = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_capture && (w_sel == 3'(i))) begin
        w_grant[i] = 1'b1;
        w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_found) w_state_d = StIrq;
      StIrq: begin
        if (w_release)              w_state_d = StIdle;
        else if (bus.interrupt_ack) w_state_d = StService;
      end
      StService: if (w_release) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b0;
    if (bus.port_id == PortData) begin
      w_rd_data = 8'(r_hold_data);
      w_rd_hit  = 1'b1;
    end else if (bus.port_id == PortStat) begin
      w_rd_data = {w_pending, 4'b0000, r_hold_ch};
      w_rd_hit  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_hold_data    <= '0;
      r_hold_ch      <= '0;
      r_rr_ptr       <= '0;
      r_mask         <= '0;
      r_in_port_data <= '0;
      r_in_port_hit  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_hold_data <= w_sel_data;
        r_hold_ch   <= w_sel;
        r_rr_ptr    <= w_rr_next;
      end
      if (w_mask_wr) r_mask <= bus.out_port[NUM_REQ-1:0];
      r_in_port_data <= w_rd_data;
      r_in_port_hit  <= w_rd_hit;
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.interrupt    = (r_state == StIrq);
  assign bus.busy         = (r_state != StIdle);
  assign bus.in_port_data = r_in_port_data;
  assign bus.in_port_hit  = r_in_port_hit;

  // Reads are side-effect free, so read_strobe is not needed.
  assign w_unused = ^{bus.read_strobe, bus.out_port, w_shift[2*NUM_REQ-1:NUM_REQ]};

endmodule

// File: tb/tb_pico_irq_arbiter.sv
// Directed, table-driven bench for pico_irq_arbiter (NUM_REQ=4, DATA_W=8, BASE_PORT=8'h10).
module tb_pico_irq_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [7:0]  pid;
    logic        ws;
    logic        ack;
    logic [3:0]  ready;
    logic        irq;
    logic        busy;
    logic        hit;
    logic [7:0]  pdata;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  vec_t tab_a[6];
  vec_t tab_b[15];

  pico_irq_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  pico_irq_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .BASE_PORT(8'h10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [7:0] pid,
                              input logic ws, input logic ack, input logic [3:0] rdy,
                              input logic irq, input logic bsy, input logic hit,
                              input logic [7:0] pd);
    vec_t r;
    r.valid = v;   r.data = d;   r.pid  = pid; r.ws  = ws;  r.ack   = ack;
    r.ready = rdy; r.irq  = irq; r.busy = bsy; r.hit = hit; r.pdata = pd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [7:0] pid,
                       input logic ws, input logic [7:0] op, input logic ack);
    bus.req_valid     = v;
    bus.req_data      = d;
    bus.port_id       = pid;
    bus.write_strobe  = ws;
    bus.out_port      = op;
    bus.interrupt_ack = ack;
    bus.read_strobe   = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst;
    drive(4'h0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("reset interrupt", 8'(bus.interrupt), 8'h00);
    chk("reset busy", 8'(bus.busy), 8'h00);
    chk("reset hit", 8'(bus.in_port_hit), 8'h00);
    chk("reset data", bus.in_port_data, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    drive(v.valid, v.data, v.pid, v.ws, 8'h00, v.ack);
    #1;
    chk($sformatf("%s%0d ready", tag, idx), 8'(bus.req_ready), 8'(v.ready));
    chk($sformatf("%s%0d interrupt", tag, idx), 8'(bus.interrupt), 8'(v.irq));
    chk($sformatf("%s%0d busy", tag, idx), 8'(bus.busy), 8'(v.busy));
    chk($sformatf("%s%0d hit", tag, idx), 8'(bus.in_port_hit), 8'(v.hit));
    chk($sformatf("%s%0d data", tag, idx), bus.in_port_data, v.pdata);
    tick();
  endtask

  localparam logic [31:0] DA = 32'h00A5_0000;
  localparam logic [31:0] DB = 32'h3332_3130;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b1;

    // Single capture on ch2, data/status reads, release, stale status read.
    tab_a[0] = mk(4'b0100, DA, 8'h00, 0, 0, 4'b0100, 0, 0, 0, 8'h00);
    tab_a[1] = mk(4'b0000, DA, 8'h10, 0, 0, 4'b0000, 1, 1, 0, 8'h00);
    tab_a[2] = mk(4'b0000, DA, 8'h11, 0, 0, 4'b0000, 1, 1, 1, 8'hA5);
    tab_a[3] = mk(4'b0000, DA, 8'h12, 1, 0, 4'b0000, 1, 1, 1, 8'h82);
    tab_a[4] = mk(4'b0000, DA, 8'h11, 0, 0, 4'b0000, 0, 0, 0, 8'h00);
    tab_a[5] = mk(4'b0000, DA, 8'h00, 0, 0, 4'b0000, 0, 0, 1, 8'h02);

    // All requesters valid, immediate ack then release: order 0,1,2,3,0 every 3 cycles.
    tab_b[0]  = mk(4'hF, DB, 8'h10, 0, 0, 4'b0001, 0, 0, 0, 8'h00);
    tab_b[1]  = mk(4'hF, DB, 8'h10, 0, 1, 4'b0000, 1, 1, 1, 8'h00);
    tab_b[2]  = mk(4'hF, DB, 8'h12, 1, 0, 4'b0000, 0, 1, 1, 8'h30);
    tab_b[3]  = mk(4'hF, DB, 8'h10, 0, 0, 4'b0010, 0, 0, 0, 8'h00);
    tab_b[4]  = mk(4'hF, DB, 8'h10, 0, 1, 4'b0000, 1, 1, 1, 8'h30);
    tab_b[5]  = mk(4'hF, DB, 8'h12, 1, 0, 4'b0000, 0, 1, 1, 8'h31);
    tab_b[6]  = mk(4'hF, DB, 8'h10, 0, 0, 4'b0100, 0, 0, 0, 8'h00);
    tab_b[7]  = mk(4'hF, DB, 8'h10, 0, 1, 4'b0000, 1, 1, 1, 8'h31);
    tab_b[8]  = mk(4'hF, DB, 8'h12, 1, 0, 4'b0000, 0, 1, 1, 8'h32);
    tab_b[9]  = mk(4'hF, DB, 8'h10, 0, 0, 4'b1000, 0, 0, 0, 8'h00);
    tab_b[10] = mk(4'hF, DB, 8'h10, 0, 1, 4'b0000, 1, 1, 1, 8'h32);
    tab_b[11] = mk(4'hF, DB, 8'h12, 1, 0, 4'b0000, 0, 1, 1, 8'h33);
    tab_b[12] = mk(4'hF, DB, 8'h10, 0, 0, 4'b0001, 0, 0, 0, 8'h00);
    tab_b[13] = mk(4'hF, DB, 8'h10, 0, 1, 4'b0000, 1, 1, 1, 8'h33);
    tab_b[14] = mk(4'hF, DB, 8'h12, 1, 0, 4'b0000, 0, 1, 1, 8'h30);

    rst();
    for (int i = 0; i < 6; i++) run_vec("A", i, tab_a[i]);
    rst();
    for (int i = 0; i < 15; i++) run_vec("B", i, tab_b[i]);

    // Mask: same-cycle write uses old mask; then ch1/ch3 alternate; clear in SERVICE.
    rst();
    drive(4'hF, DB, 8'h13, 1, 8'h05, 0); #1;
    chk("C same-cycle mask grant ch0", 8'(bus.req_ready), 8'b0001);
    tick();
    drive(4'hF, DB, 8'h12, 1, 8'h00, 0); #1;
    chk("C no grant in irq", 8'(bus.req_ready), 8'h00);
    tick();
    drive(4'hF, DB, 8'h00, 0, 8'h00, 0); #1;
    chk("C masked grant ch1", 8'(bus.req_ready), 8'b0010);
    tick();
    drive(4'hF, DB, 8'h12, 1, 8'h00, 0); tick();
    drive(4'hF, DB, 8'h00, 0, 8'h00, 0); #1;
    chk("C masked grant ch3", 8'(bus.req_ready), 8'b1000);
    tick();
    drive(4'hF, DB, 8'h12, 1, 8'h00, 0); tick();
    drive(4'hF, DB, 8'h00, 0, 8'h00, 0); #1;
    chk("C masked grant ch1 again", 8'(bus.req_ready), 8'b0010);
    tick();
    drive(4'hF, DB, 8'h11, 0, 8'h00, 1); tick();
    drive(4'hF, DB, 8'h13, 1, 8'h00, 0); #1;
    chk("C service no grant", 8'(bus.req_ready), 8'h00);
    chk("C service interrupt low", 8'(bus.interrupt), 8'h00);
    tick();
    drive(4'hF, DB, 8'h11, 0, 8'h00, 0); tick();
    chk("C word kept after mask clear", bus.in_port_data, 8'h81);
    drive(4'hF, DB, 8'h12, 1, 8'h00, 0); tick();
    drive(4'hF, DB, 8'h00, 0, 8'h00, 0); #1;
    chk("C unmasked grant ch2", 8'(bus.req_ready), 8'b0100);
    tick();

    // Ack moves to SERVICE, second ack ignored, release clears pending.
    rst();
    drive(4'b0001, 32'h0000_005A, 8'h00, 0, 8'h00, 0); tick();
    drive(4'b0000, 32'h0000_005A, 8'h00, 0, 8'h00, 1); #1;
    chk("D interrupt before ack", 8'(bus.interrupt), 8'h01);
    tick();
    drive(4'b0000, 32'h0000_005A, 8'h11, 0, 8'h00, 1); #1;
    chk("D interrupt after ack", 8'(bus.interrupt), 8'h00);
    chk("D busy in service", 8'(bus.busy), 8'h01);
    tick();
    drive(4'b0000, 32'h0000_005A, 8'h10, 0, 8'h00, 0); #1;
    chk("D second ack ignored", 8'(bus.busy), 8'h01);
    chk("D pending status", bus.in_port_data, 8'h80);
    tick();
    drive(4'b0000, 32'h0000_005A, 8'h12, 1, 8'h00, 0); #1;
    chk("D hold data", bus.in_port_data, 8'h5A);
    tick();
    drive(4'b0000, 32'h0000_005A, 8'h11, 0, 8'h00, 0); #1;
    chk("D busy after release", 8'(bus.busy), 8'h00);
    tick();
    chk("D pending cleared", bus.in_port_data, 8'h00);
    chk("D status hit", 8'(bus.in_port_hit), 8'h01);

    // Release without ack, then simultaneous ack and release.
    rst();
    drive(4'b0010, 32'h0000_C300, 8'h00, 0, 8'h00, 0); tick();
    drive(4'b0000, 32'h0000_C300, 8'h12, 1, 8'h00, 0); #1;
    chk("E interrupt set", 8'(bus.interrupt), 8'h01);
    tick();
    drive(4'b0000, 32'h0000_C300, 8'h00, 0, 8'h00, 0); #1;
    chk("E release w/o ack interrupt", 8'(bus.interrupt), 8'h00);
    chk("E release w/o ack idle", 8'(bus.busy), 8'h00);
    drive(4'b0010, 32'h0000_C300, 8'h00, 0, 8'h00, 0); #1;
    chk("E regrant ch1", 8'(bus.req_ready), 8'b0010);
    tick();
    drive(4'b0000, 32'h0000_C300, 8'h12, 1, 8'h00, 1); tick();
    #1;
    chk("E ack+release interrupt", 8'(bus.interrupt), 8'h00);
    chk("E ack+release idle", 8'(bus.busy), 8'h00);

    // Asynchronous reset mid-IRQ; rr_ptr returns to 0.
    rst();
    drive(4'b0100, 32'h0, 8'h00, 0, 8'h00, 0); tick();
    drive(4'hF, 32'h0, 8'h00, 0, 8'h00, 0); #1;
    chk("F interrupt before reset", 8'(bus.interrupt), 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("F interrupt in reset", 8'(bus.interrupt), 8'h00);
    chk("F busy in reset", 8'(bus.busy), 8'h00);
    chk("F ready in reset", 8'(bus.req_ready), 8'h00);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("F rr_ptr reset grant ch0", 8'(bus.req_ready), 8'b0001);
    drive(4'b1000, 32'h0, 8'h00, 0, 8'h00, 0); #1;
    chk("F single ch3 grant", 8'(bus.req_ready), 8'b1000);
    tick();
    drive(4'b0000, 32'h0, 8'h11, 0, 8'h00, 0); tick();
    chk("F captured ch3 status", bus.in_port_data, 8'h83);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pico_irq_arbiter.md
Name: pico_irq_arbiter

Overview:
- Interrupt-driven input scheduler for the kcpsm6 port bus.
- Shares the single processor input path between NUM_REQ external requesters using valid/ready handshakes and round-robin arbitration.
- Captures one word at a time into a holding register, raises `interrupt`, then waits for the program to read the word and release the slot.
- Sits beside kcpsm6 at top level; its read data is muxed into `in_port` whenever `in_port_hit` is high.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, requester data width (≤8, zero-extended onto the port bus).
- BASE_PORT, 8'h10, first of four consecutive port_id addresses used by this block.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
- port_id  input  8  kcpsm6 port address.
- read_strobe  input  1  kcpsm6 read strobe.
- write_strobe  input  1  kcpsm6 write strobe.
- out_port  input  8  kcpsm6 write data.
- in_port_data  output  8  registered read data for `in_port`.
- in_port_hit  output  1  registered; high when port_id was in BASE_PORT..BASE_PORT+1 on the previous cycle.
- interrupt  output  1  to kcpsm6 `interrupt`.
- interrupt_ack  input  1  from kcpsm6.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: state=IDLE, hold_data=0, hold_ch=0, rr_ptr=0, mask=0 (all requesters enabled), req_ready=0, interrupt=0, in_port_data=0, in_port_hit=0, busy=0.
- Port map:
  - BASE+0 read: hold_data, zero-extended.
  - BASE+1 read: {pending, 4'b0, hold_ch[2:0]}. pending=1 in IRQ or SERVICE.
  - BASE+2 write: release; out_port value is ignored.
  - BASE+3 write: mask[NUM_REQ-1:0]=out_port. A set bit blocks that requester.
- Read path: in_port_data and in_port_hit update every cycle from the current port_id, giving 1-cycle latency. This is independent of read_strobe. Reads have no side effects.
- FSM states: IDLE, IRQ, SERVICE.
  - IDLE:
    - eligible = req_valid & ~mask.
    - If eligible≠0, choose the first set bit searching upward from rr_ptr, with wrap-around.
    - req_ready[sel] is combinationally high in that cycle only.
    - At the edge: hold_data=req_data[sel], hold_ch=sel, rr_ptr=(sel+1) mod NUM_REQ, interrupt←1, state→IRQ.
    - If eligible=0, stay in IDLE with req_ready=0.
  - IRQ:
    - interrupt stays high.
    - interrupt_ack at an edge → interrupt←0, state→SERVICE.
    - A release write in IRQ (same or different cycle as ack) → interrupt←0, state→IDLE. Release takes priority over ack.
  - SERVICE:
    - interrupt=0.
    - Release write → state→IDLE.
    - interrupt_ack is ignored.
- Grant and data rules:
  - req_ready is 0 in IRQ and SERVICE. At most one bit is high at any time.
  - The first grant after release can occur in the cycle after the return to IDLE. Minimum spacing between captures is 3 cycles.
  - hold_data and hold_ch stay stable from capture until the next capture. Reads after release return the stale value with pending=0.
- Mask rules:
  - Mask writes are accepted in any state.
  - A mask write takes effect from the next cycle's arbitration. It never cancels a word already captured.
  - If a mask write and a grant occur in the same IDLE cycle, the grant uses the old mask.
- Boundary cases:
  - Requesters may drop req_valid without a transfer. The arbiter holds no per-requester state apart from rr_ptr.
  - Writes to BASE+0 or BASE+1 are ignored.
  - port_id outside BASE..BASE+3 gives in_port_hit=0 and in_port_data=0.
  - Reset asserted mid-operation returns to reset values immediately. The pending word is lost, and the requester has already completed its handshake.

Test Plan:
- Reset, then req_valid=4'b0100 with req_data[2]=8'hA5 → req_ready=4'b0100 for 1 cycle; next cycle interrupt=1 and busy=1; port_id=BASE+0 gives in_port_data=8'hA5 one cycle later; BASE+1 gives 8'h82.
- All four requesters valid continuously, with ack and release on each → capture order 0,1,2,3,0; no grant while busy; captures exactly 3 cycles apart when ack and release are issued immediately.
- Write mask=8'h05 at BASE+3, all requesters valid → only channels 1 and 3 alternate; write mask=0 while in SERVICE → the current word is unaffected and the next arbitration includes channel 2 after rr_ptr.
- In IRQ, pulse interrupt_ack → interrupt falls next edge, state SERVICE, pending=1; a second ack has no effect; release write → busy=0 and pending=0.
- Release without ack while in IRQ → interrupt=0 and state IDLE next edge; simultaneous ack+release → IDLE, not SERVICE.
- Deassert reset_n asynchronously mid-IRQ → interrupt, busy and req_ready go to 0 immediately; rr_ptr=0 after release; the next single request on channel 3 is granted.
